vreg_seq_writer: RTL and testbench

VREG_SEQ_WRITER -- requirements
Module: vreg_seq_writer

---
 rtl/vreg_seq_writer.sv | 162 ++++++++++++++++
 tb/tb_vreg_seq_writer.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vreg_seq_writer.sv
// vreg_seq_writer
//
// Accepts a whole-vector write request (16 elements x 16 bits) and streams it into a
// vector register file one element per cycle.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   req_valid  request present
//   req_ready  request accepted this cycle (IDLE and not in reset)
//   req_addr   target vector register (0..15)
//   req_data   payload; element i = bits [16i+15:16i]
//   req_len    element count 0..16 (larger values clamp to 16)
//   req_mask   per-element write enable (only with VREG_SEQ_WRITER_MASK_EN)
//   wEn        element write strobe
//   wAddr      register-file write address
//   wInd       element index within the register
//   wData      element value
//   busy       high while writing or completing
//   done       one-cycle completion pulse
//
// Build option: define VREG_SEQ_WRITER_MASK_EN to add req_mask. Masked elements keep
// their time slot but drive wEn=0, so request timing does not depend on the mask.

module vreg_seq_writer (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [3:0]   req_addr,
    input  logic [255:0] req_data,
    input  logic [4:0]   req_len,
`ifdef VREG_SEQ_WRITER_MASK_EN
    input  logic [15:0]  req_mask,
`endif
    output logic         wEn,
    output logic [3:0]   wAddr,
    output logic [3:0]   wInd,
    output logic [15:0]  wData,
    output logic         busy,
    output logic         done
);

    typedef enum logic [1:0] {StIdle, StWrite, StDone} state_e;

    state_e        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [3:0]    addr_q, addr_d;
    logic [255:0]  data_q, data_d;
    logic [4:0]    len_q, len_d;
`ifdef VREG_SEQ_WRITER_MASK_EN
    logic [15:0]   mask_q, mask_d;
`endif
    logic          elem_en;

    logic          wen_q, wen_d;
    logic [3:0]    waddr_q, waddr_d;
    logic [3:0]    wind_q, wind_d;
    logic [15:0]   wdata_q, wdata_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    // Ready is combinational so that it drops during reset.
    assign req_ready = (state_q == StIdle) && rst_n;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        data_d  = data_q;
        len_d   = len_q;
`ifdef VREG_SEQ_WRITER_MASK_EN
        mask_d  = mask_q;
`endif

        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    addr_d  = req_addr;
                    data_d  = req_data;
                    len_d   = (req_len > 5'd16) ? 5'd16 : req_len;
`ifdef VREG_SEQ_WRITER_MASK_EN
                    mask_d  = req_mask;
`endif
                    cnt_d   = '0;
                    state_d = (req_len == 5'd0) ? StDone : StWrite;
                end
            end
            StWrite: begin
                // len_q is 1..16 here, so len_q-1 fits in the 4-bit counter: no wrap.
                if ({1'b0, cnt_q} == (len_q - 5'd1)) begin
                    state_d = StDone;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_q + 4'd1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

`ifdef VREG_SEQ_WRITER_MASK_EN
        elem_en = mask_d[cnt_d];
`else
        elem_en = 1'b1;
`endif

        // Outputs are registered from the next state so they line up with state_q.
        wen_d   = (state_d == StWrite) && elem_en;
        waddr_d = wen_d ? addr_d : 4'd0;
        wind_d  = wen_d ? cnt_d : 4'd0;
        wdata_d = wen_d ? data_d[{cnt_d, 4'b0000} +: 16] : 16'd0;
        busy_d  = (state_d != StIdle);
        done_d  = (state_d == StDone);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            len_q   <= '0;
`ifdef VREG_SEQ_WRITER_MASK_EN
            mask_q  <= '0;
`endif
            wen_q   <= 1'b0;
            waddr_q <= '0;
            wind_q  <= '0;
            wdata_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            len_q   <= len_d;
`ifdef VREG_SEQ_WRITER_MASK_EN
            mask_q  <= mask_d;
`endif
            wen_q   <= wen_d;
            waddr_q <= waddr_d;
            wind_q  <= wind_d;
            wdata_q <= wdata_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign wEn   = wen_q;
    assign wAddr = waddr_q;
    assign wInd  = wind_q;
    assign wData = wdata_q;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule

// File: tb/tb_vreg_seq_writer.sv
// Testbench for vreg_seq_writer: table of requests plus hand-written sequences for
// mid-write reset and back-to-back requests with req_valid held high. Expected element
// writes go into a queue when a request is driven and are popped by a negedge monitor.

module tb_vreg_seq_writer;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         req_valid;
    logic         req_ready;
    logic [3:0]   req_addr;
    logic [255:0] req_data;
    logic [4:0]   req_len;
`ifdef VREG_SEQ_WRITER_MASK_EN
    logic [15:0]  req_mask;
`endif
    logic         wEn;
    logic [3:0]   wAddr;
    logic [3:0]   wInd;
    logic [15:0]  wData;
    logic         busy;
    logic         done;

    always #5 clk = ~clk;

    vreg_seq_writer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_len   (req_len),
`ifdef VREG_SEQ_WRITER_MASK_EN
        .req_mask  (req_mask),
`endif
        .wEn       (wEn),
        .wAddr     (wAddr),
        .wInd      (wInd),
        .wData     (wData),
        .busy      (busy),
        .done      (done)
    );

    typedef struct packed {
        logic [3:0]  a;
        logic [3:0]  i;
        logic [15:0] d;
    } wr_t;

    typedef struct {
        logic [3:0]  addr;
        logic [4:0]  len;
        logic [15:0] mask;
        logic [15:0] base;
        int          exp_done;  // negedge index (after acceptance) carrying done
    } vec_t;

    wr_t exp_q[$];
    int  n_pass  = 0;
    int  n_total = 0;
    bit  mon_en  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    function automatic logic [255:0] mk_data(input logic [15:0] base);
        logic [255:0] d;
        for (int i = 0; i < 16; i++) d[16*i +: 16] = base + 16'(i);
        return d;
    endfunction

    function automatic logic [15:0] eff_mask(input logic [15:0] m);
`ifdef VREG_SEQ_WRITER_MASK_EN
        return m;
`else
        return (m === 16'hxxxx) ? 16'hFFFF : 16'hFFFF;
`endif
    endfunction

    task automatic push_exp(input logic [3:0] addr, input logic [4:0] len,
                            input logic [255:0] data, input logic [15:0] mask);
        int          leff;
        logic [15:0] m;
        leff = (len > 5'd16) ? 16 : int'(len);
        m    = eff_mask(mask);
        for (int i = 0; i < leff; i++)
            if (m[i]) exp_q.push_back({addr, 4'(i), data[16*i +: 16]});
    endtask

    task automatic drive_req(input logic [3:0] addr, input logic [4:0] len,
                             input logic [255:0] data, input logic [15:0] mask);
        req_valid = 1'b1;
        req_addr  = addr;
        req_len   = len;
        req_data  = data;
`ifdef VREG_SEQ_WRITER_MASK_EN
        req_mask  = mask;
`endif
        push_exp(addr, len, data, mask);
    endtask

    // Waits (bounded) at negedges for req_ready; returns with the clock at a negedge.
    task automatic wait_ready(output bit ok);
        int waited = 0;
        @(negedge clk);
        while (!req_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        check("ready_wait", req_ready, 1);
        ok = req_ready;
    endtask

    // Monitor: every write must match the head of the expected queue; idle outputs are 0.
    always @(negedge clk) begin
        if (mon_en) begin
            if (wEn) begin
                check("write_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    wr_t e;
                    e = exp_q.pop_front();
                    check("wAddr", wAddr, e.a);
                    check("wInd", wInd, e.i);
                    check("wData", wData, e.d);
                end
            end else begin
                check("idle_outputs_zero", {wAddr, wInd, wData}, 0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[7];
        bit   ok;
        int   done_at;
        int   pulses;

        vecs[0] = '{addr: 4'd3,  len: 5'd16, mask: 16'hFFFF, base: 16'h1000, exp_done: 17};
        vecs[1] = '{addr: 4'd5,  len: 5'd0,  mask: 16'hFFFF, base: 16'h2222, exp_done: 1};
        vecs[2] = '{addr: 4'd7,  len: 5'd20, mask: 16'hFFFF, base: 16'h3000, exp_done: 17};
        vecs[3] = '{addr: 4'd1,  len: 5'd1,  mask: 16'hFFFF, base: 16'hABCD, exp_done: 2};
        vecs[4] = '{addr: 4'd15, len: 5'd8,  mask: 16'h00AA, base: 16'h5000, exp_done: 9};
        vecs[5] = '{addr: 4'd9,  len: 5'd15, mask: 16'hF0F0, base: 16'h7000, exp_done: 16};
        vecs[6] = '{addr: 4'd0,  len: 5'd31, mask: 16'hFFFF, base: 16'h8000, exp_done: 17};

        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_addr  = '0;
        req_len   = '0;
        req_data  = '0;
`ifdef VREG_SEQ_WRITER_MASK_EN
        req_mask  = '0;
`endif

        // Reset state.
        repeat (3) @(negedge clk);
        check("ready_in_reset", req_ready, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_wEn", wEn, 0);
        check("reset_done", done, 0);
        check("reset_busy", busy, 0);
        check("reset_outs", {wAddr, wInd, wData}, 0);
        check("ready_after_reset", req_ready, 1);
        mon_en = 1'b1;

        // Table-driven requests.
        for (int v = 0; v < 7; v++) begin
            wait_ready(ok);
            if (ok) begin
                drive_req(vecs[v].addr, vecs[v].len, mk_data(vecs[v].base), vecs[v].mask);
                @(posedge clk);
                #1 req_valid = 1'b0;
                done_at = 0;
                pulses  = 0;
                for (int n = 1; n <= 20; n++) begin
                    @(negedge clk);
                    if (done) begin
                        pulses++;
                        if (done_at == 0) done_at = n;
                    end
                    if (n <= vecs[v].exp_done) check($sformatf("busy_v%0d_n%0d", v, n), busy, 1);
                    if (n == vecs[v].exp_done + 1)
                        check($sformatf("ready_back_v%0d", v), req_ready, 1);
                end
                check($sformatf("done_cycle_v%0d", v), done_at, vecs[v].exp_done);
                check($sformatf("done_pulses_v%0d", v), pulses, 1);
                check($sformatf("writes_drained_v%0d", v), exp_q.size(), 0);
            end
        end

        // Reset after the second of four writes: two writes seen, no done pulse.
        wait_ready(ok);
        if (ok) begin
            req_valid = 1'b1;
            req_addr  = 4'd2;
            req_len   = 5'd4;
            req_data  = mk_data(16'h4000);
`ifdef VREG_SEQ_WRITER_MASK_EN
            req_mask  = 16'hFFFF;
`endif
            push_exp(4'd2, 5'd2, req_data, 16'hFFFF);
            @(posedge clk);
            #1 req_valid = 1'b0;
            @(negedge clk);
            @(negedge clk);
            rst_n = 1'b0;
            @(negedge clk);
            check("abort_wEn", wEn, 0);
            check("abort_busy", busy, 0);
            check("abort_done", done, 0);
            check("abort_ready_low", req_ready, 0);
            rst_n  = 1'b1;
            pulses = 0;
            for (int n = 0; n < 6; n++) begin
                @(negedge clk);
                if (done) pulses++;
            end
            check("abort_no_done", pulses, 0);
            check("abort_two_writes", exp_q.size(), 0);
        end

        // req_valid held high with changing data: second accept only after DONE.
        wait_ready(ok);
        if (ok) begin
            drive_req(4'd6, 5'd2, mk_data(16'hA000), 16'hFFFF);
            @(posedge clk);
            for (int k = 1; k <= 4; k++) begin
                @(negedge clk);
                req_data = mk_data(16'hB000 + 16'(k * 16'h0100));
                check($sformatf("held_ready_k%0d", k), req_ready, (k == 4) ? 1 : 0);
            end
            push_exp(4'd6, 5'd2, req_data, 16'hFFFF);
            @(posedge clk);
            #1 req_valid = 1'b0;
            pulses = 0;
            for (int n = 1; n <= 8; n++) begin
                @(negedge clk);
                if (done) pulses++;
            end
            check("held_second_done", pulses, 1);
            check("held_writes_drained", exp_q.size(), 0);
        end

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
